// File: rtl/fpu_operand_stage_if.sv
// Handshake and operand bus between the operand producer, fpu_operand_stage and the adder core.
// The slave modport is the stage's view; the master modport is the environment's view.
interface fpu_operand_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_A_out;
    logic [31:0] op_B_out;
    logic        bypass;
    logic [31:0] bypass_data;
    logic [3:0]  bypass_status;
    logic [2:0]  class_a;
    logic [2:0]  class_b;
    logic [15:0] issue_count;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, op_A_out, op_B_out, bypass, bypass_data,
        output bypass_status, class_a, class_b, issue_count
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, op_A_out, op_B_out, bypass, bypass_data,
        input  bypass_status, class_a, class_b, issue_count
    );
endinterface

// File: rtl/fpu_operand_stage.sv
// FPU operand stage: 2-entry operand FIFO feeding a registered classify/special-case stage.
// Define FPU_FTZ_EN to flush subnormal operands to a signed zero before classification.
module fpu_operand_stage (
    input  logic                 clk,
    input  logic                 reset,
    fpu_operand_stage_if.slave   bus
);

    localparam int unsigned Depth = 2;

    localparam logic [2:0] ClsZero = 3'd0;
    localparam logic [2:0] ClsSub  = 3'd1;
    localparam logic [2:0] ClsNorm = 3'd2;
    localparam logic [2:0] ClsInf  = 3'd3;
    localparam logic [2:0] ClsQnan = 3'd4;
    localparam logic [2:0] ClsSnan = 3'd5;

    localparam logic [3:0]  StatusExact   = 4'b0001;
    localparam logic [3:0]  StatusInvalid = 4'b0000;
    localparam logic [31:0] QuietNan      = 32'h7FC0_0000;

    function automatic logic [31:0] flush(input logic [31:0] x);
`ifdef FPU_FTZ_EN
        if (x[30:23] == 8'h00) return {x[31], 31'b0};
        return x;
`else
        return x;
`endif
    endfunction

    function automatic logic [2:0] classify(input logic [31:0] x);
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'b0) return ClsInf;
            return x[22] ? ClsQnan : ClsSnan;
        end
        if (x[30:23] == 8'h00) return (x[22:0] == 23'b0) ? ClsZero : ClsSub;
        return ClsNorm;
    endfunction

    // FIFO state
    logic [31:0] mem_a_q [Depth];
    logic [31:0] mem_b_q [Depth];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        push, pop, load;

    // Output register state
    logic        out_valid_q, out_valid_d;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic        bypass_q, bypass_d;
    logic [31:0] bypass_data_q, bypass_data_d;
    logic [3:0]  bypass_status_q, bypass_status_d;
    logic [2:0]  class_a_q, class_a_d, class_b_q, class_b_d;
    logic [15:0] issue_q, issue_d;

    logic [31:0] head_a, head_b;
    logic [2:0]  head_cls_a, head_cls_b;
    logic        head_byp;
    logic [31:0] head_byp_data;
    logic [3:0]  head_byp_status;

    assign bus.in_ready = (count_q < 2'd2);
    assign push = bus.in_valid && bus.in_ready;
    // The output register can take a new pair when empty or being drained this cycle.
    assign load = !out_valid_q || bus.out_ready;
    assign pop  = load && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    assign head_a     = flush(mem_a_q[rd_ptr_q]);
    assign head_b     = flush(mem_b_q[rd_ptr_q]);
    assign head_cls_a = classify(head_a);
    assign head_cls_b = classify(head_b);

    always_comb begin
        logic a_nan, b_nan, a_inf, b_inf;
        a_nan = (head_cls_a == ClsQnan) || (head_cls_a == ClsSnan);
        b_nan = (head_cls_b == ClsQnan) || (head_cls_b == ClsSnan);
        a_inf = (head_cls_a == ClsInf);
        b_inf = (head_cls_b == ClsInf);
        head_byp        = 1'b1;
        head_byp_data   = QuietNan;
        head_byp_status = StatusInvalid;
        if (a_nan || b_nan) begin
            head_byp_data   = QuietNan;
        end else if (a_inf && b_inf && (head_a[31] != head_b[31])) begin
            head_byp_data   = QuietNan;
        end else if (a_inf) begin
            head_byp_data   = head_a;
            head_byp_status = StatusExact;
        end else if (b_inf) begin
            head_byp_data   = head_b;
            head_byp_status = StatusExact;
        end else if ((head_cls_a == ClsZero) && (head_cls_b == ClsZero)) begin
            head_byp_data   = {head_a[31] & head_b[31], 31'b0};
            head_byp_status = StatusExact;
        end else begin
            head_byp        = 1'b0;
            head_byp_data   = 32'b0;
            head_byp_status = StatusExact;
        end
    end

    always_comb begin
        out_valid_d     = out_valid_q;
        op_a_d          = op_a_q;
        op_b_d          = op_b_q;
        bypass_d        = bypass_q;
        bypass_data_d   = bypass_data_q;
        bypass_status_d = bypass_status_q;
        class_a_d       = class_a_q;
        class_b_d       = class_b_q;
        issue_d         = issue_q;
        if (out_valid_q && bus.out_ready) issue_d = issue_q + 16'd1;
        if (load) begin
            out_valid_d = pop;
            if (pop) begin
                op_a_d          = head_a;
                op_b_d          = head_b;
                bypass_d        = head_byp;
                bypass_data_d   = head_byp_data;
                bypass_status_d = head_byp_status;
                class_a_d       = head_cls_a;
                class_b_d       = head_cls_b;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_a_q[i] <= 32'b0;
                mem_b_q[i] <= 32'b0;
            end
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            out_valid_q     <= 1'b0;
            op_a_q          <= 32'b0;
            op_b_q          <= 32'b0;
            bypass_q        <= 1'b0;
            bypass_data_q   <= 32'b0;
            bypass_status_q <= StatusExact;
            class_a_q       <= ClsZero;
            class_b_q       <= ClsZero;
            issue_q         <= 16'd0;
        end else begin
            if (push) begin
                mem_a_q[wr_ptr_q] <= bus.in_a;
                mem_b_q[wr_ptr_q] <= bus.in_b;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q         <= count_d;
            out_valid_q     <= out_valid_d;
            op_a_q          <= op_a_d;
            op_b_q          <= op_b_d;
            bypass_q        <= bypass_d;
            bypass_data_q   <= bypass_data_d;
            bypass_status_q <= bypass_status_d;
            class_a_q       <= class_a_d;
            class_b_q       <= class_b_d;
            issue_q         <= issue_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.op_A_out      = op_a_q;
    assign bus.op_B_out      = op_b_q;
    assign bus.bypass        = bypass_q;
    assign bus.bypass_data   = bypass_data_q;
    assign bus.bypass_status = bypass_status_q;
    assign bus.class_a       = class_a_q;
    assign bus.class_b       = class_b_q;
    assign bus.issue_count   = issue_q;

    // ClsSub/ClsNorm are produced through classify(); referenced here only for readability.
    logic unused_cls;
    assign unused_cls = ^{ClsSub, ClsNorm};

endmodule

// File: tb/tb_fpu_operand_stage.sv
// Directed self-checking bench for fpu_operand_stage: special cases, latency, back-pressure
// and mid-transfer reset.
module tb_fpu_operand_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpu_operand_stage_if bus ();

    fpu_operand_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pair through an idle stage with out_ready high; checks latency and all outputs.
    task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_opa, input logic exp_byp,
                         input logic [31:0] exp_data, input logic [3:0] exp_status,
                         input logic [2:0] exp_ca, input logic [2:0] exp_cb);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = 32'hDEAD_BEEF;
        check({tag, " latency"}, 32'(bus.out_valid), 32'd0);
        tick();
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, " op_A"}, bus.op_A_out, exp_opa);
        check({tag, " op_B"}, bus.op_B_out, b);
        check({tag, " bypass"}, 32'(bus.bypass), 32'(exp_byp));
        check({tag, " data"}, bus.bypass_data, exp_data);
        check({tag, " status"}, 32'(bus.bypass_status), 32'(exp_status));
        check({tag, " class_a"}, 32'(bus.class_a), 32'(exp_ca));
        check({tag, " class_b"}, 32'(bus.class_b), 32'(exp_cb));
        tick();
        check({tag, " drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    logic [31:0] sub_opa;
    logic [2:0]  sub_cls;
    logic        acc;
    int unsigned n_acc;

    initial begin
`ifdef FPU_FTZ_EN
        sub_opa = 32'h0000_0000;
        sub_cls = 3'd0;
`else
        sub_opa = 32'h0000_0001;
        sub_cls = 3'd1;
`endif
        bus.in_valid  = 1'b0;
        bus.in_a      = 32'b0;
        bus.in_b      = 32'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b0;
        #12;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst bypass", 32'(bus.bypass), 32'd0);
        check("rst issue", 32'(bus.issue_count), 32'd0);
        check("rst op_A", bus.op_A_out, 32'd0);
        check("rst op_B", bus.op_B_out, 32'd0);
        check("rst data", bus.bypass_data, 32'd0);
        check("rst status", 32'(bus.bypass_status), 32'b0001);
        check("rst class_a", 32'(bus.class_a), 32'd0);
        check("rst class_b", 32'(bus.class_b), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("rel in_ready", 32'(bus.in_ready), 32'd1);

        // Operand pins must be ignored without in_valid.
        bus.in_a = 32'h7F80_0000;
        bus.in_b = 32'hFF80_0000;
        tick();
        tick();
        check("idle no push", 32'(bus.out_valid), 32'd0);

        apply("nan",     32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 32'h7FC0_0000, 4'b0000, 3'd4, 3'd2);
        apply("opp_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 4'b0000, 3'd3, 3'd3);
        apply("neg_zero", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 4'b0001, 3'd0, 3'd0);
        apply("subnorm", 32'h0000_0001, 32'h3F80_0000, sub_opa, 1'b0, 32'h0, 4'b0001, sub_cls, 3'd2);
        apply("one_inf", 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 1'b1, 32'hFF80_0000, 4'b0001, 3'd3, 3'd2);
        apply("normal",  32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 1'b0, 32'h0, 4'b0001, 3'd2, 3'd2);
        apply("snan",    32'h7F80_0001, 32'h0000_0000, 32'h7F80_0001, 1'b1, 32'h7FC0_0000, 4'b0000, 3'd5, 3'd0);
        apply("mix_zero", 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 32'h0, 4'b0001, 3'd0, 3'd0);
        apply("same_inf", 32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7F80_0000, 4'b0001, 3'd3, 3'd3);
        check("issue after vectors", 32'(bus.issue_count), 32'd9);

        // Back-pressure: four pairs offered while the consumer stalls.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 32'h4000_0000 + 32'(k);
            bus.in_b     = 32'h3F80_0000;
            acc          = bus.in_ready;
            tick();
            if (acc) n_acc++;
        end
        bus.in_valid = 1'b0;
        check("bp accepted", 32'(n_acc), 32'd3);
        check("bp in_ready", 32'(bus.in_ready), 32'd0);
        check("bp held valid", 32'(bus.out_valid), 32'd1);
        tick();
        check("bp stable", bus.op_A_out, 32'h4000_0000);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp order%0d valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp order%0d op_A", k), bus.op_A_out, 32'h4000_0000 + 32'(k));
            tick();
        end
        check("bp drained", 32'(bus.out_valid), 32'd0);
        check("bp issue", 32'(bus.issue_count), 32'd3);

        // Reset mid-transfer with pairs buffered.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 32'h4100_0000 + 32'(k);
            bus.in_b     = 32'h3F80_0000;
            tick();
        end
        bus.in_valid = 1'b0;
        check("mid pending", 32'(bus.out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid async", 32'(bus.out_valid), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("mid out_valid", 32'(bus.out_valid), 32'd0);
        check("mid issue", 32'(bus.issue_count), 32'd0);
        check("mid in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("mid no ghost", 32'(bus.out_valid), 32'd0);
        check("mid no ghost issue", 32'(bus.issue_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_operand_stage.md
FPU_OPERAND_STAGE -- requirements
Module: fpu_operand_stage

Interface
REQ-001 SHALL have a port `clk`, input, 1 bit: rising-edge clock.
REQ-002 SHALL have a port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have a port `in_valid`, input, 1 bit: an operand pair is offered.
REQ-004 SHALL have a port `in_ready`, output, 1 bit: the stage accepts the offered pair.
REQ-005 SHALL have ports `in_a` and `in_b`, input, 32 bits each: IEEE-754 single-precision operands.
REQ-006 SHALL have a port `out_valid`, output, 1 bit: the output register holds a pair.
REQ-007 SHALL have a port `out_ready`, input, 1 bit: the adder core or the result mux consumes the output.
REQ-008 SHALL have ports `op_A_out` and `op_B_out`, output, 32 bits each: operands forwarded to the adder core.
REQ-009 SHALL have a port `bypass`, output, 1 bit: the result is precomputed and the core is skipped.
REQ-010 SHALL have a port `bypass_data`, output, 32 bits: the precomputed result.
REQ-011 SHALL have a port `bypass_status`, output, 4 bits, with encodings:
- 0001: EXACT
- 0010: INEXACT
- 0100: OVERFLOW
- 1000: UNDERFLOW
- 0000: INVALID
REQ-012 SHALL have ports `class_a` and `class_b`, output, 3 bits each, with encodings:
- 0: zero
- 1: subnormal
- 2: normal
- 3: infinity
- 4: quiet NaN
- 5: signalling NaN
REQ-013 SHALL have a port `issue_count`, output, 16 bits: number of pairs consumed at the output.

Function
REQ-014 SHALL buffer input pairs in a 2-entry FIFO; a push occurs when `in_valid` and `in_ready` are both high at a clock edge.
REQ-015 SHALL drive `in_ready` high exactly when FIFO occupancy is below 2.
REQ-016 SHALL keep an occupancy counter (0..2) and 1-bit read/write pointers that wrap 1->0.
REQ-017 SHALL load the output register from the FIFO head when the register is empty, or when `out_valid` and `out_ready` are both high in the same cycle.
REQ-018 SHALL give 1-cycle latency: a pair pushed at edge N into an empty FIFO with an empty output register has `out_valid` high after edge N+1.
REQ-019 SHALL allow push and pop in the same cycle at occupancy 1; occupancy stays 1 and the FIFO order is preserved.
REQ-020 SHALL hold `op_A_out`, `op_B_out`, `bypass*` and `class_*` stable while `out_valid` is high and `out_ready` is low.
REQ-021 SHALL compute class and bypass as a registered function of the FIFO head when it is loaded into the output register.
REQ-022 SHALL apply the bypass rules in priority order:
- (a) Either operand is NaN: bypass=1, data 0x7FC00000, status 0000.
- (b) Infinities of opposite sign: bypass=1, data 0x7FC00000, status 0000.
- (c) Exactly one operand infinite, or both infinite with the same sign: bypass=1, data = that infinity, status 0001.
- (d) Both operands zero: bypass=1, data 0x80000000 if both signs are 1, otherwise 0x00000000, status 0001.
- (e) Otherwise: bypass=0, `bypass_data` 0, `bypass_status` 0001.
REQ-023 SHALL forward `op_A_out` and `op_B_out` unmodified regardless of bypass, except under REQ-029.
REQ-024 SHALL increment `issue_count` on each cycle where `out_valid` and `out_ready` are both high, wrapping 0xFFFF->0x0000.
REQ-025 SHALL ignore `in_a` and `in_b` when `in_valid` is low.

Reset
REQ-026 SHALL, while `reset` is low, force the following regardless of `clk`:
- FIFO occupancy 0 and pointers 0
- `out_valid`, `bypass` and `issue_count` 0
- `op_A_out`, `op_B_out` and `bypass_data` 0
- `bypass_status` 0001
- `class_a` and `class_b` 0
REQ-027 SHALL discard buffered pairs and a pending output when reset asserts mid-transfer; no pair SHALL reappear after release.
REQ-028 SHALL drive `in_ready` high in the first cycle after reset release.

Configuration
REQ-029 SHALL, with `FPU_FTZ_EN` defined, flush subnormal inputs to a zero of the same sign:
- `op_*_out` carries the flushed value.
- `class_*` reports 0.
- The bypass rules see a zero.
REQ-030 SHALL, without `FPU_FTZ_EN`, pass subnormal inputs unchanged and classify them as 1.

Verification
REQ-031 SHALL cover the NaN case: in_a=0x7FC00000, in_b=0x3F800000 -> bypass=1, bypass_data=0x7FC00000, status=0000, class_a=4.
REQ-032 SHALL cover the opposite-infinity case: in_a=0x7F800000, in_b=0xFF800000 -> bypass=1, data=0x7FC00000, status=0000.
REQ-033 SHALL cover the negative-zero case: in_a=0x80000000, in_b=0x80000000 -> bypass=1, data=0x80000000, status=0001.
REQ-034 SHALL cover back-pressure: out_ready=0 with 4 pairs offered ->
- 3 pairs are accepted (2 in the FIFO, 1 in the output register) and `in_ready` falls.
- After `out_ready` rises, outputs emerge in order and `issue_count` reaches 3.
REQ-035 SHALL cover the subnormal input 0x00000001 + 0x3F800000:
- With `FPU_FTZ_EN`: op_A_out=0x00000000, class_a=0.
- Without `FPU_FTZ_EN`: op_A_out=0x00000001, class_a=1.
- In both builds: bypass=0.
REQ-036 SHALL cover reset mid-transfer: reset pulsed low with 2 pairs buffered -> out_valid=0, issue_count=0, in_ready=1 after release.
